// File: rtl/lsu_mem_if.sv
// lsu_mem_if: RV32I load/store initiator for a word-only data memory (optional LSU_RANGE_CHECK_EN).
module lsu_mem_if #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, RD, WR, RESP, ERR} state_t;
`ifdef LSU_RANGE_CHECK_EN
    localparam logic RANGE_EN = 1'b1;
`else
    localparam logic RANGE_EN = 1'b0;
`endif
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS) << 2;
    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, data_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        accept, req_err;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [4:0]  sh;
    logic [31:0] load_val, lane_mask, lane_data, merged;
    assign accept     = req_valid && req_ready;
    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == RESP || state_q == ERR;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_read   = rst_n && state_q == RD;
    assign mem_write  = rst_n && state_q == WR;
    assign mem_addr   = (state_q == RD || state_q == WR) ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wdata  = state_q == WR ? merged : 32'h0;
    // classify the live request: misalignment, illegal funct3, out-of-range
    always_comb begin
        req_err = (RANGE_EN && req_addr >= MEM_BYTES)
                | (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
                | (req_funct3[1:0] == 2'b01 && req_addr[0])
                | (req_we ? req_funct3 > 3'b010 : (req_funct3[1:0] == 2'b11 || req_funct3 == 3'b110));
    end
    // load lane extraction and sub-word store merge on the latched request
    always_comb begin
        byte_v    = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_v    = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_val  = f3_q[1:0] == 2'b00 ? {{24{byte_v[7] & ~f3_q[2]}}, byte_v}
                  : f3_q[1:0] == 2'b01 ? {{16{half_v[15] & ~f3_q[2]}}, half_v}
                  : mem_rdata;
        sh        = f3_q[0] ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
        lane_mask = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        lane_data = (f3_q[0] ? {16'h0, wdata_q[15:0]} : {24'h0, wdata_q[7:0]}) << sh;
        merged    = f3_q[1] ? wdata_q : (data_q & ~lane_mask) | lane_data;
    end
    // next state and the response registers loaded on entry to RESP/ERR
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = req_err ? ERR : (req_we && req_funct3 == 3'b010) ? WR : RD;
                rdata_d = req_err ? 32'h0 : rdata_q;
                err_d   = req_err ? 1'b1 : err_q;
            end
            RD: begin
                state_d = we_q ? WR : RESP;
                rdata_d = we_q ? rdata_q : load_val;
                err_d   = we_q ? err_q : 1'b0;
            end
            WR: begin
                state_d = RESP;
                rdata_d = 32'h0;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and response registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
    // request latch on accept and read-word capture for the merge
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
        if (state_q == RD) data_q <= mem_rdata;
    end
endmodule
